// File: rtl/filter_test_sequencer_pkg.sv
// Shared settings for the filter test sequencer: bus widths, the delay
// codes driven to the signal generator, settle time and the sequencer states.
package package_settings;

  localparam int SIZE_DELAY       = 8;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int NUM_FILTERS      = 10;

  localparam int SETTLE_CYCLES = 16;

  localparam logic [SIZE_DELAY-1:0] DELAY_LO = 8'd10;
  localparam logic [SIZE_DELAY-1:0] DELAY_HI = 8'd200;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_REPORT  = 3'd3,
    S_DONE    = 3'd4
  } seq_state_t;

  // Generator control word for one test step
  typedef struct packed {
    logic                  overlay;
    logic                  rate;
    logic [SIZE_DELAY-1:0] delay;
  } gen_ctrl_t;

  // Step k -> generator controls: bit0 overlay, bit1 rate, bit2 long delay
  function automatic gen_ctrl_t step_decode(input logic [2:0] k);
    gen_ctrl_t c;
    c.overlay = k[0];
    c.rate    = k[1];
    c.delay   = k[2] ? DELAY_HI : DELAY_LO;
    return c;
  endfunction

endpackage

// File: rtl/seq_peak_tracker.sv
// Signed running maximum. With en high, clr restarts the maximum from the
// current sample; otherwise the sample is folded into the held maximum.
// peak_now already includes the current sample so the caller can capture
// the final result on the same edge as the last sample.
module seq_peak_tracker
#(
  parameter int W = 16
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] peak_now
);

  logic signed [W-1:0] peak_q;

  // Next maximum: load on clear, keep the larger value otherwise
  always_comb begin
    peak_now = peak_q;
    if (en) begin
      if (clr || (sample > peak_q)) peak_now = sample;
    end
  end

  // Held maximum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) peak_q <= '0;
    else        peak_q <= peak_now;
  end

endmodule

// File: rtl/filter_test_sequencer.sv
// Filter test sequencer: steps the signal generator through NUM_STEPS
// control settings, lets the filters settle, then tracks the signed peak
// of one selected filter output and reports it per step.
module filter_test_sequencer
  import package_settings::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int DWELL_W   = 16
)(
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic [DWELL_W-1:0]                              dwell,
  input  logic [3:0]                                      sel_filter,
  input  logic [NUM_FILTERS-1:0][SIZE_FILTER_DATA-1:0]    filter_data,
  output logic                                            test_overlay,
  output logic                                            test_rate,
  output logic [SIZE_DELAY-1:0]                           test_delay,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            peak_valid,
  output logic [2:0]                                      peak_step,
  output logic [SIZE_FILTER_DATA-1:0]                     peak_value
);

  // Counter must hold both the settle time and the largest dwell
  localparam int CNT_W = (DWELL_W > 5) ? DWELL_W : 5;

  seq_state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2:0]         step;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_eff;
  logic [3:0]         sel_q;
  gen_ctrl_t          ctrl_q;

  logic settle_last, meas_last, last_step;
  logic trk_en, trk_clr;
  logic signed [SIZE_FILTER_DATA-1:0] sample, peak_now;

  // A dwell of zero still measures one sample
  assign dwell_eff   = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign meas_last   = (cnt == CNT_W'(dwell_eff - DWELL_W'(1)));
  assign last_step   = (step == 3'(NUM_STEPS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start)       state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_last) state_nxt = S_MEASURE;
      S_MEASURE: if (meas_last)   state_nxt = S_REPORT;
      S_REPORT:  state_nxt = last_step ? S_DONE : S_SETTLE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs and tracker controls
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    peak_valid = 1'b0;
    trk_en     = 1'b0;
    trk_clr    = 1'b0;
    case (state)
      S_SETTLE:  busy = 1'b1;
      S_MEASURE: begin
        busy    = 1'b1;
        trk_en  = 1'b1;
        trk_clr = (cnt == '0);
      end
      S_REPORT: begin
        busy       = 1'b1;
        peak_valid = 1'b1;
      end
      S_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Phase counter: runs within SETTLE/MEASURE, restarts on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if ((state_nxt == state) &&
                 ((state == S_SETTLE) || (state == S_MEASURE))) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Run parameters latched on an accepted start; step advances after REPORT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step    <= '0;
      dwell_q <= '0;
      sel_q   <= '0;
    end else if ((state == S_IDLE) && start) begin
      step    <= '0;
      dwell_q <= dwell;
      sel_q   <= (sel_filter > 4'd9) ? 4'd9 : sel_filter;
    end else if ((state == S_REPORT) && !last_step) begin
      step <= step + 3'd1;
    end
  end

  // Generator controls load on SETTLE entry and hold until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else if ((state_nxt == S_SETTLE) && (state != S_SETTLE)) begin
      ctrl_q <= step_decode((state == S_IDLE) ? 3'd0 : (step + 3'd1));
    end
  end

  assign test_overlay = ctrl_q.overlay;
  assign test_rate    = ctrl_q.rate;
  assign test_delay   = ctrl_q.delay;

  assign sample = $signed(filter_data[sel_q]);

  seq_peak_tracker #(
    .W (SIZE_FILTER_DATA)
  ) u_peak (
    .clk      (clk),
    .reset    (reset),
    .clr      (trk_clr),
    .en       (trk_en),
    .sample   (sample),
    .peak_now (peak_now)
  );

  // Capture the result on the last MEASURE edge so it is shown during REPORT
  // and held until the next step's REPORT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_step  <= '0;
      peak_value <= '0;
    end else if ((state == S_MEASURE) && meas_last) begin
      peak_step  <= step;
      peak_value <= peak_now;
    end
  end

endmodule
